// File: rtl/fpga_row_cfg_loader.sv
// ============================================================================
// Module   : fpga_row_cfg_loader
// Purpose  : Bit-serial configuration loader for one FPGA row. Hunts for a
//            sync word, deserialises a fixed-length payload into a shadow
//            register, verifies an 8-bit interleaved XOR checksum and commits
//            the shadow atomically to the live routing/logic select outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_row_cfg_loader #(
  parameter int         WIRE_WIDTH  = 3,
  parameter int         FPGA_WIDTH  = 5,
  parameter int         LB_CFG_SIZE = 5,
  parameter logic [7:0] SYNC        = 8'hA5,
  localparam int        BRB_W       = FPGA_WIDTH * WIRE_WIDTH * 12,
  localparam int        BSB_W       = (FPGA_WIDTH - 1) * WIRE_WIDTH * WIRE_WIDTH * 12,
  localparam int        LB_W        = (FPGA_WIDTH - 1) * LB_CFG_SIZE,
  localparam int        TOTAL       = BRB_W + BSB_W + LB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_abort,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             cfg_busy,
  output logic             cfg_loaded,
  output logic [BRB_W-1:0] brbselect,
  output logic [BSB_W-1:0] bsbselect,
  output logic [LB_W-1:0]  lbselect
);

  localparam int                 IDX_W    = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             r_state;
  logic [7:0]         r_sync_sr;
  logic [7:0]         r_chk;
  logic [TOTAL-1:0]   r_shadow;
  logic [IDX_W-1:0]   r_idx;
  logic [2:0]         r_j;
  logic               r_mismatch;
  logic               r_done;
  logic               r_err;
  logic               r_loaded;
  logic [BRB_W-1:0]   r_brb;
  logic [BSB_W-1:0]   r_bsb;
  logic [LB_W-1:0]    r_lb;

  logic               w_xfer;
  logic [7:0]         w_sync_next;
  logic               w_chk_bad;

  // The only state that refuses bits is the single commit cycle.
  assign cfg_ready   = (r_state != S_COMMIT);
  assign cfg_busy    = (r_state != S_HUNT);
  assign w_xfer      = cfg_valid & cfg_ready;
  assign w_sync_next = {r_sync_sr[6:0], cfg_in};
  assign w_chk_bad   = (cfg_in != r_chk[r_j]);

  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign cfg_loaded  = r_loaded;
  assign brbselect   = r_brb;
  assign bsbselect   = r_bsb;
  assign lbselect    = r_lb;

  // Frame FSM: sync hunt, payload shift-in, checksum verify, atomic commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HUNT;
      r_sync_sr  <= '0;
      r_chk      <= '0;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_j        <= '0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_loaded   <= 1'b0;
      r_brb      <= '0;
      r_bsb      <= '0;
      r_lb       <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (cfg_abort) begin
            r_sync_sr <= '0;
          end else if (w_xfer) begin
            if (w_sync_next == SYNC) begin
              // Window is emptied so a later re-hunt starts from scratch.
              r_state   <= S_LOAD;
              r_idx     <= '0;
              r_chk     <= '0;
              r_sync_sr <= '0;
            end else begin
              r_sync_sr <= w_sync_next;
            end
          end
        end
        S_LOAD: begin
          if (cfg_abort) begin
            r_state <= S_HUNT;
          end else if (w_xfer) begin
            r_shadow[r_idx]      <= cfg_in;
            r_chk[r_idx[2:0]]    <= r_chk[r_idx[2:0]] ^ cfg_in;
            if (r_idx == LAST_IDX) begin
              r_state    <= S_CHECK;
              r_idx      <= '0;
              r_j        <= '0;
              r_mismatch <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (cfg_abort) begin
            r_state <= S_HUNT;
          end else if (w_xfer) begin
            if (r_j == 3'd7) begin
              r_j <= '0;
              if (r_mismatch | w_chk_bad) begin
                r_err   <= 1'b1;
                r_state <= S_HUNT;
              end else begin
                r_state <= S_COMMIT;
              end
            end else begin
              r_mismatch <= r_mismatch | w_chk_bad;
              r_j        <= r_j + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          // Abort is deliberately ignored here: a verified frame always lands.
          r_brb     <= r_shadow[BRB_W-1:0];
          r_bsb     <= r_shadow[BRB_W +: BSB_W];
          r_lb      <= r_shadow[BRB_W+BSB_W +: LB_W];
          r_done    <= 1'b1;
          r_loaded  <= 1'b1;
          r_sync_sr <= '0;
          r_state   <= S_HUNT;
        end
        default: begin
          r_state <= S_HUNT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpga_row_cfg_loader.sv
// ============================================================================
// Module   : tb_fpga_row_cfg_loader
// Purpose  : Scoreboard bench for fpga_row_cfg_loader. Stimulus pushes the
//            expected commit/error event per frame; a monitor pops and checks
//            on every cfg_done/cfg_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpga_row_cfg_loader;

  localparam int BRB_W = 180;
  localparam int BSB_W = 432;
  localparam int LB_W  = 20;
  localparam int TOTAL = 632;
  localparam logic [7:0] SYNC = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_in;
  logic             cfg_valid;
  logic             cfg_abort;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
  logic             cfg_busy;
  logic             cfg_loaded;
  logic [BRB_W-1:0] brbselect;
  logic [BSB_W-1:0] bsbselect;
  logic [LB_W-1:0]  lbselect;

  fpga_row_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_in     (cfg_in),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .cfg_busy   (cfg_busy),
    .cfg_loaded (cfg_loaded),
    .brbselect  (brbselect),
    .bsbselect  (bsbselect),
    .lbselect   (lbselect)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_err;
    logic [TOTAL-1:0] cfg;     // expected live config, packed brb|bsb|lb LSB-first
    bit               loaded;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_tests   = 0;
  int               n_fail    = 0;
  int               n_commits = 0;
  int               ready_low = 0;
  bit               gap_mode  = 0;
  logic [TOTAL-1:0] committed = '0;   // model of live outputs
  bit               loaded_m  = 0;

  task automatic check(input string name, input logic [TOTAL-1:0] act,
                       input logic [TOTAL-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TOTAL-1:0] live_cfg();
    return {lbselect, bsbselect, brbselect};
  endfunction

  // Checksum from the frame rule: check bit j is the XOR of payload bits k with k mod 8 == j.
  function automatic logic [7:0] calc_chk(input logic [TOTAL-1:0] p);
    logic [7:0] c = '0;
    for (int k = 0; k < TOTAL; k++) c[k % 8] = c[k % 8] ^ p[k];
    return c;
  endfunction

  function automatic logic [TOTAL-1:0] rand_payload();
    logic [TOTAL-1:0] p;
    for (int k = 0; k < TOTAL; k++) p[k] = 1'($urandom_range(1, 0));
    return p;
  endfunction

  // Monitor: every done/err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!cfg_ready) ready_low++;
      if (cfg_done || cfg_err) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%b err=%b with no event expected", cfg_done, cfg_err);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", TOTAL'({cfg_err, cfg_done}), mon_e.is_err ? TOTAL'(2'b10) : TOTAL'(2'b01));
          check("live_cfg", live_cfg(), mon_e.cfg);
          check("loaded_at_pulse", TOTAL'(cfg_loaded), TOTAL'(mon_e.loaded));
        end
      end
    end
  end

  // Offer one bit until accepted; random idle cycles inserted in gap mode.
  task automatic send_bit(input logic b);
    bit ok = 0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if (gap_mode && ($urandom_range(1, 0) == 1)) begin
        cfg_valid = 1'b0;
        cfg_in    = 1'($urandom_range(1, 0));
      end else begin
        cfg_valid = 1'b1;
        cfg_in    = b;
        ok        = cfg_ready;
      end
      @(posedge clk);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: bit not accepted within 64 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
    end
  endtask

  // Send sync + payload + checksum (XOR'ed with flip). abort_at/reset_at >= 0
  // cut the frame at that payload index.
  task automatic send_frame(input logic [TOTAL-1:0] p, input logic [7:0] flip,
                            input int abort_at, input int reset_at);
    exp_t       e;
    logic [7:0] c;
    logic [7:0] s;
    c = calc_chk(p) ^ flip;
    s = SYNC;
    if (abort_at < 0 && reset_at < 0) begin
      if (flip == 8'h00) begin
        committed = p;
        loaded_m  = 1;
        n_commits++;
        e.is_err  = 0;
      end else begin
        e.is_err  = 1;
      end
      e.cfg    = committed;
      e.loaded = loaded_m;
      sb.push_back(e);
    end
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
    for (int k = 0; k < TOTAL; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_in    = p[k];
        cfg_abort = 1'b1;
        @(posedge clk);
        idle(2);
        return;
      end
      if (k == reset_at) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        committed = '0;
        loaded_m  = 0;
        #1;
        check("rst_live_cfg", live_cfg(), '0);
        check("rst_busy", TOTAL'(cfg_busy), '0);
        check("rst_loaded", TOTAL'(cfg_loaded), '0);
        check("rst_ready", TOTAL'(cfg_ready), TOTAL'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      send_bit(p[k]);
    end
    for (int j = 0; j < 8; j++) send_bit(c[j]);
    idle(3);
  endtask

  logic [TOTAL-1:0] pa;
  logic [TOTAL-1:0] pb;
  logic [TOTAL-1:0] pc;
  logic [7:0]       noise;

  initial begin
    rst_n     = 1'b0;
    cfg_in    = 1'b0;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", TOTAL'(cfg_ready), TOTAL'(1));
    check("reset_busy", TOTAL'(cfg_busy), '0);
    check("reset_pulses", TOTAL'({cfg_done, cfg_err}), '0);
    check("reset_loaded", TOTAL'(cfg_loaded), '0);
    check("reset_live_cfg", live_cfg(), '0);
    rst_n = 1'b1;
    idle(2);

    // 1: brb all ones, rest zero
    pa = '0;
    pa[BRB_W-1:0] = '1;
    send_frame(pa, 8'h00, -1, -1);
    check("t1_loaded", TOTAL'(cfg_loaded), TOTAL'(1));
    check("t1_brb_ones", TOTAL'(brbselect), TOTAL'({BRB_W{1'b1}}));

    // 2: same frame, checksum bit 3 flipped, from a fresh reset
    rst_n = 1'b0;
    committed = '0;
    loaded_m  = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(pa, 8'h08, -1, -1);
    check("t2_live_cfg", live_cfg(), '0);
    check("t2_loaded", TOTAL'(cfg_loaded), '0);

    // 3: A commits, B aborted at bit 300, C commits
    pa = rand_payload();
    pb = rand_payload();
    pc = rand_payload();
    send_frame(pa, 8'h00, -1, -1);
    send_frame(pb, 8'h00, 300, -1);
    check("t3_hold_after_abort", live_cfg(), pa);
    check("t3_busy_after_abort", TOTAL'(cfg_busy), '0);
    send_frame(pc, 8'h00, -1, -1);
    check("t3_frame_c", live_cfg(), pc);

    // 4: noise AA preceding the sync; lbselect tile 0 = 5'h13
    noise = 8'hAA;
    for (int i = 7; i >= 0; i--) send_bit(noise[i]);
    pb = rand_payload();
    pb[BRB_W+BSB_W +: 5] = 5'h13;
    send_frame(pb, 8'h00, -1, -1);
    check("t4_lb_tile0", TOTAL'(lbselect[4:0]), TOTAL'(5'h13));

    // 5: same payload gap-free then with 50% valid gaps
    pc = rand_payload();
    send_frame(pc, 8'h00, -1, -1);
    gap_mode = 1;
    send_frame(pc, 8'h00, -1, -1);
    gap_mode = 0;
    check("t5_gapped_result", live_cfg(), pc);

    // 6: reset at payload bit 100 after a prior commit, then fresh frame
    send_frame(pa, 8'h00, -1, -1);
    send_frame(pb, 8'h00, -1, 100);
    pc = rand_payload();
    send_frame(pc, 8'h00, -1, -1);
    check("t6_after_reset", live_cfg(), pc);

    // Random mix: good, corrupt, aborted frames
    for (int r = 0; r < 4; r++) begin
      pa = rand_payload();
      case ($urandom_range(2, 0))
        0:       send_frame(pa, 8'h00, -1, -1);
        1:       send_frame(pa, 8'(1 << $urandom_range(7, 0)), -1, -1);
        default: send_frame(pa, 8'h00, $urandom_range(TOTAL - 1, 0), -1);
      endcase
      check("rand_hold", live_cfg(), committed);
    end

    idle(10);
    check("sb_drained", TOTAL'(sb.size()), '0);
    check("ready_low_per_commit", TOTAL'(ready_low), TOTAL'(n_commits));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
